// File: rtl/crack_field.sv
// Explosion-flame renderer: up to N_SLOTS bombs each burn a range-limited cross of tiles
// for FLAME_FRAMES frames; the current scan pixel is classified two cycles later.
module crack_field #(
  parameter int N_SLOTS      = 6,
  parameter int COORD_W      = 6,
  parameter int BLOCK_SHIFT  = 4,
  parameter int PX_OFFSET    = 1,
  parameter int RANGE        = 2,
  parameter int FLAME_FRAMES = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [N_SLOTS-1:0]         fire,
  input  logic [N_SLOTS*COORD_W-1:0] bomb_x,
  input  logic [N_SLOTS*COORD_W-1:0] bomb_y,
  input  logic [9:0]                 px,
  input  logic [9:0]                 py,
  output logic                       crack,
  output logic                       crack_center,
  output logic [N_SLOTS-1:0]         active,
  output logic [N_SLOTS-1:0]         done
);

  localparam int                  TIMER_W    = $clog2(FLAME_FRAMES + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(FLAME_FRAMES);
  localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);
  localparam logic [COORD_W:0]    RANGE_L    = (COORD_W + 1)'(RANGE);

  typedef enum logic {
    IDLE = 1'b0,
    BURN = 1'b1
  } slot_state_e;

  slot_state_e        state_r     [N_SLOTS];
  slot_state_e        state_nxt_s [N_SLOTS];
  logic [TIMER_W-1:0] timer_r     [N_SLOTS];
  logic [TIMER_W-1:0] timer_nxt_s [N_SLOTS];
  logic [COORD_W-1:0] bx_r        [N_SLOTS];
  logic [COORD_W-1:0] by_r        [N_SLOTS];
  logic [COORD_W-1:0] bx_nxt_s    [N_SLOTS];
  logic [COORD_W-1:0] by_nxt_s    [N_SLOTS];
  logic [N_SLOTS-1:0] done_nxt_s;

  logic [10:0]        px_adj_s;
  logic [COORD_W-1:0] tx_s;
  logic [COORD_W-1:0] ty_s;
  logic [COORD_W-1:0] tx_r;
  logic [COORD_W-1:0] ty_r;
  logic               hit_s;
  logic               center_s;

  // Signed distance with one extra bit so tile 0 and the last tile never alias.
  function automatic logic [COORD_W:0] tile_dist(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[COORD_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Per-slot burn FSM next state: fire only arms an idle slot, ticks count down a burning one.
  always_comb begin
    done_nxt_s = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      state_nxt_s[i] = state_r[i];
      timer_nxt_s[i] = timer_r[i];
      bx_nxt_s[i]    = bx_r[i];
      by_nxt_s[i]    = by_r[i];
      case (state_r[i])
        IDLE: begin
          if (fire[i]) begin
            state_nxt_s[i] = BURN;
            timer_nxt_s[i] = TIMER_LOAD;
            bx_nxt_s[i]    = bomb_x[i*COORD_W +: COORD_W];
            by_nxt_s[i]    = bomb_y[i*COORD_W +: COORD_W];
          end else begin
            state_nxt_s[i] = IDLE;
          end
        end
        BURN: begin
          if (frame_tick && (timer_r[i] == TIMER_ONE)) begin
            state_nxt_s[i] = IDLE;
            timer_nxt_s[i] = '0;
            done_nxt_s[i]  = 1'b1;
          end else if (frame_tick) begin
            timer_nxt_s[i] = timer_r[i] - TIMER_ONE;
          end else begin
            timer_nxt_s[i] = timer_r[i];
          end
        end
        default: begin
          state_nxt_s[i] = IDLE;
          timer_nxt_s[i] = '0;
        end
      endcase
    end
  end

  // Slot state, timer, latched coordinates and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_r[i] <= IDLE;
        timer_r[i] <= '0;
        bx_r[i]    <= '0;
        by_r[i]    <= '0;
      end
      done <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_r[i] <= state_nxt_s[i];
        timer_r[i] <= timer_nxt_s[i];
        bx_r[i]    <= bx_nxt_s[i];
        by_r[i]    <= by_nxt_s[i];
      end
      done <= done_nxt_s;
    end
  end

  // Active flags come straight from the slot state flops.
  always_comb begin
    active = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      active[i] = (state_r[i] == BURN);
    end
  end

  // Pixel to tile mapping; the high bits past COORD_W are intentionally dropped.
  always_comb begin
    px_adj_s = {1'b0, px} + 11'(PX_OFFSET);
    tx_s     = COORD_W'(px_adj_s >> BLOCK_SHIFT);
    ty_s     = COORD_W'(py >> BLOCK_SHIFT);
  end

  // Arms only exist along odd rows/columns, mirroring the maze's wall grid.
  always_comb begin
    logic lit_s, col_s, row_s, vert_s, horz_s;
    hit_s    = 1'b0;
    center_s = 1'b0;
    lit_s    = 1'b0;
    col_s    = 1'b0;
    row_s    = 1'b0;
    vert_s   = 1'b0;
    horz_s   = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      lit_s    = (state_r[i] == BURN);
      col_s    = (tx_r == bx_r[i]);
      row_s    = (ty_r == by_r[i]);
      vert_s   = col_s & tx_r[0] & (tile_dist(ty_r, by_r[i]) <= RANGE_L);
      horz_s   = row_s & ty_r[0] & (tile_dist(tx_r, bx_r[i]) <= RANGE_L);
      center_s = center_s | (lit_s & col_s & row_s);
      hit_s    = hit_s | (lit_s & ((col_s & row_s) | vert_s | horz_s));
    end
  end

  // Two-stage pixel pipeline: tile coordinates, then the registered classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r         <= '0;
      ty_r         <= '0;
      crack        <= 1'b0;
      crack_center <= 1'b0;
    end else begin
      tx_r         <= tx_s;
      ty_r         <= ty_s;
      crack        <= hit_s;
      crack_center <= center_s;
    end
  end

endmodule

// File: tb/tb_crack_field.sv
// Scoreboard bench for crack_field: stimulus queues hand-computed expectations tagged with
// the cycle they fall due; a negedge monitor compares and retires them.
module tb_crack_field;

  localparam int NS = 6;
  localparam int CW = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_tick;
  logic [NS-1:0]    fire;
  logic [NS*CW-1:0] bomb_x;
  logic [NS*CW-1:0] bomb_y;
  logic [9:0]       px;
  logic [9:0]       py;
  logic             crack;
  logic             crack_center;
  logic [NS-1:0]    active;
  logic [NS-1:0]    done;

  crack_field #(
    .N_SLOTS(NS), .COORD_W(CW), .BLOCK_SHIFT(4), .PX_OFFSET(1), .RANGE(2), .FLAME_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .px(px), .py(py),
    .crack(crack), .crack_center(crack_center), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    bit            chk_pix;
    bit            chk_st;
    logic          crack;
    logic          center;
    logic [NS-1:0] act;
    logic [NS-1:0] dn;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic int tpx(input int t);
    return 16 * t + 5;
  endfunction

  function automatic int tpy(input int t);
    return 16 * t + 3;
  endfunction

  task automatic push(input int lat, input bit cp, input bit cs, input logic c, input logic cc,
                      input logic [NS-1:0] a, input logic [NS-1:0] d, input string nm);
    exp_t e;
    e.due = cyc + lat; e.chk_pix = cp; e.chk_st = cs;
    e.crack = c; e.center = cc; e.act = a; e.dn = d;
    sb.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic expect_pix(input logic c, input logic cc, input string nm);
    push(2, 1'b1, 1'b0, c, cc, '0, '0, nm);
  endtask

  task automatic expect_st(input logic [NS-1:0] a, input logic [NS-1:0] d, input string nm);
    push(1, 1'b0, 1'b1, 1'b0, 1'b0, a, d, nm);
  endtask

  task automatic drive(input logic r, input logic [NS-1:0] f, input logic t, input int x, input int y);
    rst = r; fire = f; frame_tick = t; px = 10'(x); py = 10'(y);
  endtask

  task automatic set_bomb(input int s, input int x, input int y);
    bomb_x[s*CW +: CW] = CW'(x);
    bomb_y[s*CW +: CW] = CW'(y);
  endtask

  // Monitor: retire every expectation that falls due on this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        if (sb[i].chk_pix) begin
          n_vec++;
          if (crack !== sb[i].crack || crack_center !== sb[i].center) begin
            n_bad++;
            $display("FAIL %s: crack/center got %b/%b want %b/%b", nm_q[i], crack, crack_center,
                     sb[i].crack, sb[i].center);
          end
        end
        if (sb[i].chk_st) begin
          n_vec++;
          if (active !== sb[i].act || done !== sb[i].dn) begin
            n_bad++;
            $display("FAIL %s: active/done got %b/%b want %b/%b", nm_q[i], active, done,
                     sb[i].act, sb[i].dn);
          end
        end
        sb.delete(i);
        nm_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    int g2 [10][4] = '{'{tpx(5), tpy(5), 1, 0}, '{tpx(3), tpy(7), 1, 0}, '{tpx(1), tpy(5), 1, 0},
                       '{tpx(3), tpy(3), 1, 0}, '{tpx(6), tpy(5), 0, 0}, '{tpx(3), tpy(8), 0, 0},
                       '{tpx(4), tpy(6), 0, 0}, '{tpx(3), tpy(2), 0, 0}, '{94, tpy(5), 1, 0},
                       '{95, tpy(5), 0, 0}};
    int g3 [7][4]  = '{'{tpx(1), tpy(1), 1, 0}, '{tpx(2), tpy(1), 1, 0}, '{tpx(3), tpy(1), 0, 0},
                       '{tpx(63), tpy(1), 0, 0}, '{tpx(0), tpy(2), 0, 0}, '{tpx(0), tpy(0), 0, 0},
                       '{1023, tpy(1), 1, 1}};
    int g5 [5][4]  = '{'{tpx(4), tpy(5), 1, 0}, '{tpx(5), tpy(5), 1, 1}, '{tpx(7), tpy(5), 1, 0},
                       '{tpx(6), tpy(5), 1, 0}, '{tpx(8), tpy(5), 0, 0}};
    bomb_x = '0; bomb_y = '0;
    set_bomb(0, 3, 5); set_bomb(1, 0, 1); set_bomb(2, 10, 11); set_bomb(5, 5, 5);
    drive(1'b1, '0, 1'b0, tpx(3), tpy(5));
    @(negedge clk); @(negedge clk);
    expect_st('0, '0, "rst_status"); expect_pix(1'b0, 1'b0, "rst_pixel");
    @(negedge clk);

    // Bomb at (3,5): pixel scanned the cycle before the fire must stay dark.
    drive(1'b0, '0, 1'b0, tpx(3), tpy(5));
    expect_pix(1'b0, 1'b0, "pre_fire"); expect_st('0, '0, "idle");
    @(negedge clk);
    drive(1'b0, 6'b000001, 1'b0, tpx(3), tpy(5));
    expect_pix(1'b1, 1'b1, "center"); expect_st(6'b000001, '0, "fire0");
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, '0, 1'b0, g2[k][0], g2[k][1]);
      expect_pix(1'(g2[k][2]), 1'(g2[k][3]), $sformatf("cross%0d", k));
      @(negedge clk);
    end

    // Countdown with a re-fire (new coords on the bus) between ticks.
    drive(1'b0, '0, 1'b1, tpx(3), tpy(5));
    expect_st(6'b000001, '0, "tick1"); expect_pix(1'b1, 1'b1, "tick1_lit");
    @(negedge clk);
    set_bomb(0, 9, 9);
    drive(1'b0, 6'b000001, 1'b0, tpx(3), tpy(5));
    expect_st(6'b000001, '0, "refire"); expect_pix(1'b1, 1'b1, "refire_keep");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, tpx(9), tpy(9));
    expect_pix(1'b0, 1'b0, "refire_newxy");
    @(negedge clk);
    drive(1'b0, '0, 1'b1, tpx(3), tpy(5));
    expect_st(6'b000001, '0, "tick2");
    @(negedge clk);
    drive(1'b0, '0, 1'b1, tpx(3), tpy(5));
    expect_st('0, 6'b000001, "tick3_done"); expect_pix(1'b0, 1'b0, "expired");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, tpx(3), tpy(5));
    expect_st('0, '0, "done_once");
    @(negedge clk);
    drive(1'b0, '0, 1'b1, tpx(3), tpy(5));
    expect_st('0, '0, "idle_tick");
    @(negedge clk);

    // Bomb at the (0,1) corner: no wrap, and px=1023 truncates back to tile 0.
    drive(1'b0, 6'b000010, 1'b0, tpx(0), tpy(1));
    expect_pix(1'b1, 1'b1, "edge_center"); expect_st(6'b000010, '0, "fire1");
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, '0, 1'b0, g3[k][0], g3[k][1]);
      expect_pix(1'(g3[k][2]), 1'(g3[k][3]), $sformatf("edge%0d", k));
      @(negedge clk);
    end

    // Slots 0 and 5 overlap on row 5, then reset lands mid-burn.
    set_bomb(0, 3, 5);
    drive(1'b0, 6'b100001, 1'b0, tpx(4), tpy(5));
    expect_st(6'b100011, '0, "fire05");
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b0, g5[k][0], g5[k][1]);
      expect_pix(1'(g5[k][2]), 1'(g5[k][3]), $sformatf("overlap%0d", k));
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, tpx(4), tpy(5));
    @(negedge clk);
    drive(1'b1, '0, 1'b0, tpx(4), tpy(5));
    push(1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, "mid_rst");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, tpx(4), tpy(5));
    expect_st('0, '0, "post_rst"); expect_pix(1'b0, 1'b0, "post_rst_dark");
    @(negedge clk);

    // Fire coincident with a tick loads the full count without decrementing.
    drive(1'b0, 6'b000100, 1'b1, tpx(10), tpy(11));
    expect_st(6'b000100, '0, "fire_tick"); expect_pix(1'b1, 1'b1, "s2_center");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, tpx(12), tpy(11));
    expect_pix(1'b1, 1'b0, "s2_arm");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, tpx(10), tpy(12));
    expect_pix(1'b0, 1'b0, "s2_even_col");
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, tpx(0), tpy(0));
      if (k < 2) expect_st(6'b000100, '0, $sformatf("s2_tick%0d", k + 1));
      else       expect_st('0, 6'b000100, "s2_done");
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, tpx(0), tpy(0));
    expect_st('0, '0, "s2_after");
    @(negedge clk);

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    while (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation never retired (due %0d, now %0d)", nm_q[0], sb[0].due, cyc);
      void'(sb.pop_front());
      void'(nm_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
